// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target bridging an external SPI initiator to rx/tx valid-ready byte streams
// Ports: io_clock/io_reset system clock and sync active-high reset; io_spi_sclk/ss/mosi async SPI inputs;
// io_spi_miso/io_spi_miso_oe SPI output and enable; io_rx_* received-byte stream; io_tx_* transmit-byte stream;
// io_overrun/io_underrun one-cycle event pulses; io_active frame in progress.
// Option: define SPI_TARGET_RXFIFO_EN for a 4-entry rx FIFO instead of the single rx register.
module spi_target #(
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       io_clock,
  input  logic       io_reset,
  input  logic       io_spi_sclk,
  input  logic       io_spi_ss,
  input  logic       io_spi_mosi,
  output logic       io_spi_miso,
  output logic       io_spi_miso_oe,
  output logic       io_rx_valid,
  input  logic       io_rx_ready,
  output logic [7:0] io_rx_payload,
  input  logic       io_tx_valid,
  output logic       io_tx_ready,
  input  logic [7:0] io_tx_payload,
  output logic       io_overrun,
  output logic       io_underrun,
  output logic       io_active
);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
  state_t r_state;
  logic [SYNC_STAGES-1:0] r_sclk_s, r_ss_s, r_mosi_s;
  logic r_sclk_d, r_ss_d;
  // fills with ones after reset so WAIT_IDLE only trusts ss once the preset sync pipeline has flushed
  logic [SYNC_STAGES:0] r_settle;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_tx_shift, r_tx_hold;
  logic r_tx_full, r_oe, r_underrun, r_overrun;
  logic w_sclk, w_ss, w_mosi, w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic w_bit, w_rx_done, w_load, w_tx_cap;
  logic [7:0] w_load_byte, w_rx_byte;
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      r_sclk_s <= '0;
      r_ss_s <= '1;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_ss_d <= 1'b1;
      r_settle <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], io_spi_sclk};
      r_ss_s <= {r_ss_s[SYNC_STAGES-2:0], io_spi_ss};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], io_spi_mosi};
      r_sclk_d <= w_sclk;
      r_ss_d <= w_ss;
      r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
    end
  end
  assign w_sclk = r_sclk_s[SYNC_STAGES-1];
  assign w_ss = r_ss_s[SYNC_STAGES-1];
  assign w_mosi = r_mosi_s[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_rise = w_ss & ~r_ss_d;
  assign w_ss_fall = ~w_ss & r_ss_d;
  // sclk activity only counts when no ss edge lands in the same cycle
  assign w_bit = (r_state == ACTIVE) & ~w_ss_rise;
  assign w_rx_done = w_bit & w_sclk_rise & (r_bit_cnt == 3'd7);
  assign w_rx_byte = {r_rx_shift, w_mosi};
  // bit_cnt is 0 on a falling edge only right after a completed byte
  assign w_load = ((r_state == IDLE) & w_ss_fall) | (w_bit & w_sclk_fall & (r_bit_cnt == 3'd0));
  assign w_load_byte = r_tx_full ? r_tx_hold : IDLE_BYTE;
  assign w_tx_cap = io_tx_valid & ~r_tx_full;
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      r_state <= WAIT_IDLE;
      r_bit_cnt <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_tx_hold <= '0;
      r_tx_full <= 1'b0;
      r_oe <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load & ~r_tx_full;
      r_tx_full <= w_tx_cap | (r_tx_full & ~w_load);
      if (w_tx_cap) r_tx_hold <= io_tx_payload;
      if (w_load) r_tx_shift <= w_load_byte;
      case (r_state)
        WAIT_IDLE: if (r_settle[SYNC_STAGES] & w_ss & r_ss_d) r_state <= IDLE;
        IDLE: if (w_ss_fall) begin
          r_state <= ACTIVE;
          r_oe <= 1'b1;
          r_bit_cnt <= '0;
        end
        ACTIVE: if (w_ss_rise) begin
          r_state <= IDLE;
          r_oe <= 1'b0;
        end else if (w_sclk_rise) begin
          r_rx_shift <= {r_rx_shift[5:0], w_mosi};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end else if (w_sclk_fall && r_bit_cnt != 3'd0) begin
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end
`ifdef SPI_TARGET_RXFIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;
  logic w_pop, w_push;
  assign w_pop = (r_cnt != 3'd0) & io_rx_ready;
  assign w_push = w_rx_done & ((r_cnt != 3'd4) | w_pop);
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      r_fifo <= '{default: '0};
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_fifo[r_wp] <= w_rx_byte;
      r_wp <= r_wp + {1'b0, w_push};
      r_rp <= r_rp + {1'b0, w_pop};
      r_cnt <= r_cnt + {2'b0, w_push} - {2'b0, w_pop};
      r_overrun <= w_rx_done & ~w_push;
    end
  end
  assign io_rx_valid = r_cnt != 3'd0;
  assign io_rx_payload = r_fifo[r_rp];
`else
  logic r_rx_valid;
  logic [7:0] r_rx_payload;
  logic w_accept;
  assign w_accept = w_rx_done & (~r_rx_valid | io_rx_ready);
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      r_rx_valid <= 1'b0;
      r_rx_payload <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_rx_done & ~w_accept;
      if (w_accept) begin
        r_rx_payload <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && io_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end
  assign io_rx_valid = r_rx_valid;
  assign io_rx_payload = r_rx_payload;
`endif
  assign io_spi_miso = r_oe ? r_tx_shift[7] : 1'b1;
  assign io_spi_miso_oe = r_oe;
  assign io_tx_ready = ~r_tx_full;
  assign io_overrun = r_overrun;
  assign io_underrun = r_underrun;
  assign io_active = r_state == ACTIVE;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: scoreboard bench for spi_target driving an SPI mode-0 initiator at io_clock/16
module tb_spi_target;
  localparam int SS = 2;
  logic io_clock = 1'b0;
  logic io_reset = 1'b1;
  logic sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic rx_ready = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_payload = 8'h00;
  logic miso, miso_oe, rx_valid, tx_ready, overrun, underrun, active;
  logic [7:0] rx_payload;
  spi_target #(.SYNC_STAGES(SS), .IDLE_BYTE(8'hFF)) dut (
    .io_clock(io_clock),
    .io_reset(io_reset),
    .io_spi_sclk(sclk),
    .io_spi_ss(ss),
    .io_spi_mosi(mosi),
    .io_spi_miso(miso),
    .io_spi_miso_oe(miso_oe),
    .io_rx_valid(rx_valid),
    .io_rx_ready(rx_ready),
    .io_rx_payload(rx_payload),
    .io_tx_valid(tx_valid),
    .io_tx_ready(tx_ready),
    .io_tx_payload(tx_payload),
    .io_overrun(overrun),
    .io_underrun(underrun),
    .io_active(active)
  );
  always #5 io_clock = ~io_clock;
  int checks = 0, errors = 0;
  int n_under = 0, n_over = 0, mbits = 0;
  logic [7:0] q_rx[$];
  logic [7:0] q_miso[$];
  logic [7:0] msh = 8'h00;
  logic prev_sclk = 1'b0;
  bit miso_en = 1'b1;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge io_clock);
    #2;
  endtask
  // monitor: pulse counters, rx scoreboard on handshake, miso bytes as the initiator sees them
  always @(negedge io_clock) begin
    if (underrun) n_under++;
    if (overrun) n_over++;
    if (rx_valid && rx_ready) begin
      if (q_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %h expected none", rx_payload);
      end else check("rx_byte", rx_payload, q_rx.pop_front());
    end
    if (ss || !miso_en || io_reset) mbits = 0;
    else if (sclk && !prev_sclk) begin
      msh = {msh[6:0], miso};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        if (q_miso.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected: got %h expected none", msh);
        end else check("miso_byte", msh, q_miso.pop_front());
      end
    end
    prev_sclk = sclk;
  end
  task automatic chk_reset();
    @(negedge io_clock);
    check("rst_miso", miso, 1'b1);
    check("rst_oe", miso_oe, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_payload", rx_payload, 8'h00);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_overrun", overrun, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_active", active, 1'b0);
  endtask
  // bytes left-aligned in d; the last sclk fall coincides with ss rising
  task automatic xfer(input logic [39:0] d, input int nbits);
    ss = 1'b0;
    clks(8);
    check("frame_active", {active, miso_oe}, 8'h03);
    for (int i = 0; i < nbits; i++) begin
      mosi = d[39-i];
      clks(8);
      sclk = 1'b1;
      clks(8);
      sclk = 1'b0;
      if (i == nbits - 1) ss = 1'b1;
    end
    for (int k = 0; k < SS + 2; k++) begin
      @(negedge io_clock);
      if (!miso_oe && miso) break;
    end
    check("oe_release", {miso_oe, miso}, 8'h01);
    clks(12);
  endtask
  task automatic drain(input string name);
    for (int k = 0; k < 100 && (q_rx.size() != 0 || q_miso.size() != 0); k++) @(negedge io_clock);
    check(name, 8'(q_rx.size() + q_miso.size()), 8'h00);
    clks(1);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int u, o;
    clks(3);
    chk_reset();
    clks(1);
    io_reset = 1'b0;
    clks(10);
    // held A5 goes out while 3C comes in
    tx_payload = 8'hA5;
    tx_valid = 1'b1;
    clks(1);
    tx_valid = 1'b0;
    @(negedge io_clock);
    check("t1_tx_ready_full", tx_ready, 1'b0);
    clks(1);
    u = n_under;
    o = n_over;
    q_miso.push_back(8'hA5);
    q_rx.push_back(8'h3C);
    xfer({8'h3C, 32'h0}, 8);
    drain("t1_drain");
    check("t1_underrun", 8'(n_under - u), 8'd0);
    check("t1_tx_ready", tx_ready, 1'b1);
    // empty holding register for two bytes
    u = n_under;
    q_miso.push_back(8'hFF);
    q_miso.push_back(8'hFF);
    q_rx.push_back(8'h12);
    q_rx.push_back(8'h34);
    xfer(40'h1234000000, 16);
    drain("t2_drain");
    check("t2_underrun", 8'(n_under - u), 8'd2);
    check("t2_overrun", 8'(n_over - o), 8'd0);
    // consumer stalled
    rx_ready = 1'b0;
    o = n_over;
`ifdef SPI_TARGET_RXFIFO_EN
    repeat (5) q_miso.push_back(8'hFF);
    xfer(40'h1122334455, 40);
    @(negedge io_clock);
    check("t3_rx_valid", rx_valid, 1'b1);
    check("t3_rx_head", rx_payload, 8'h11);
    check("t3_overrun", 8'(n_over - o), 8'd1);
    clks(1);
    q_rx.push_back(8'h11);
    q_rx.push_back(8'h22);
    q_rx.push_back(8'h33);
    q_rx.push_back(8'h44);
`else
    repeat (3) q_miso.push_back(8'hFF);
    xfer(40'h1122330000, 24);
    @(negedge io_clock);
    check("t3_rx_valid", rx_valid, 1'b1);
    check("t3_rx_held", rx_payload, 8'h11);
    check("t3_overrun", 8'(n_over - o), 8'd2);
    clks(1);
    q_rx.push_back(8'h11);
`endif
    rx_ready = 1'b1;
    drain("t3_drain");
    // partial frame of 5 bits, then a full one
    o = n_over;
    xfer(40'hA800000000, 5);
    clks(5);
    @(negedge io_clock);
    check("t4_rx_valid", rx_valid, 1'b0);
    check("t4_overrun", 8'(n_over - o), 8'd0);
    clks(1);
    q_miso.push_back(8'hFF);
    q_rx.push_back(8'h96);
    xfer({8'h96, 32'h0}, 8);
    drain("t4_drain");
    // reset in the middle of a byte with ss still low
    miso_en = 1'b0;
    fork
      xfer({8'hE7, 32'h0}, 8);
      begin
        clks(8 + 16 * 3 + 4);
        io_reset = 1'b1;
        clks(3);
        chk_reset();
        clks(1);
        io_reset = 1'b0;
      end
    join
    clks(20);
    @(negedge io_clock);
    check("t5_rx_valid", rx_valid, 1'b0);
    clks(1);
    miso_en = 1'b1;
    q_miso.push_back(8'hFF);
    q_rx.push_back(8'h5A);
    xfer({8'h5A, 32'h0}, 8);
    drain("t5_drain");
    // tx byte offered during byte 1 goes out as byte 2
    u = n_under;
    q_miso.push_back(8'hFF);
    q_miso.push_back(8'hC3);
    q_rx.push_back(8'hAB);
    q_rx.push_back(8'hCD);
    fork
      xfer(40'hABCD000000, 16);
      begin
        clks(40);
        tx_payload = 8'hC3;
        tx_valid = 1'b1;
        clks(1);
        tx_valid = 1'b0;
        @(negedge io_clock);
        check("t6_tx_ready_full", tx_ready, 1'b0);
      end
    join
    drain("t6_drain");
    check("t6_underrun", 8'(n_under - u), 8'd1);
    check("t6_tx_ready", tx_ready, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI responder (target) for the SoC: the far end of the SPI initiator bus (sclk, ss, mosi, miso).
- Lets the FPGA be driven by an external SPI master, e.g. a board controller or a test host.
- Oversamples the SPI pins on the system clock and exchanges bytes with fabric logic over valid/ready streams.
- Fixed SPI mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth on sclk, ss and mosi (minimum 2).
- IDLE_BYTE, 8'hFF: byte shifted out on miso when no transmit data is available.

Ports:
- io_clock  input  1  system clock; must be at least 8x the sclk frequency.
- io_reset  input  1  synchronous, active-high reset.
- io_spi_sclk  input  1  SPI clock from the initiator (asynchronous).
- io_spi_ss  input  1  target select, active low (asynchronous).
- io_spi_mosi  input  1  initiator-to-target data.
- io_spi_miso  output  1  target-to-initiator data.
- io_spi_miso_oe  output  1  miso output enable; high only while selected.
- io_rx_valid  output  1  received byte available.
- io_rx_ready  input  1  consumer accepts io_rx_payload.
- io_rx_payload  output  8  received byte.
- io_tx_valid  input  1  producer offers io_tx_payload.
- io_tx_ready  output  1  transmit holding register is empty.
- io_tx_payload  input  8  byte to send.
- io_overrun  output  1  one-cycle pulse: received byte dropped.
- io_underrun  output  1  one-cycle pulse: IDLE_BYTE sent instead of user data.
- io_active  output  1  frame in progress (synchronised ss low, FSM in ACTIVE).

Behaviour:
Reset values:
- miso=1, miso_oe=0, rx_valid=0, rx_payload=0, tx_ready=1, overrun=0, underrun=0, active=0.
- Synchroniser flops are preset to sclk=0, ss=1, mosi=0.
- The bit counter and shift registers are cleared.

Synchronisation and edge detection:
- sclk, ss and mosi pass through SYNC_STAGES flops.
- Edges are detected by comparing against one additional registered copy.
- Each detected event acts exactly one io_clock cycle after it appears at the last sync stage.

FSM states:
- WAIT_IDLE: entered on reset. Moves to IDLE only after synchronised ss is seen high. A frame already running during reset is ignored.
- IDLE: on synchronised ss falling edge, go to ACTIVE:
  - set miso_oe=1 and clear bit_cnt to 0;
  - load tx_shift from the holding register if full (holding register becomes empty, tx_ready=1), otherwise load IDLE_BYTE and pulse underrun;
  - drive miso = tx_shift[7] on the same cycle.
- ACTIVE:
  - On sclk rising: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt++.
  - On sclk falling, bit_cnt 1..7: tx_shift shifts left, miso = new tx_shift[7].
  - When bit_cnt reaches 8 (on the rising edge):
    - deliver the byte: if rx_valid=0 or rx_ready=1 in that cycle, then rx_payload <= completed byte and rx_valid=1 on the next cycle;
    - otherwise drop the new byte, keep the old one, and pulse overrun.
    - bit_cnt returns to 0.
  - On the falling edge after byte completion: reload tx_shift with the same rule as frame start (holding register or IDLE_BYTE plus underrun).
  - On ss rising: go to IDLE, miso_oe=0, miso=1. A partial byte is discarded (no rx_valid, no overrun). The holding register keeps any byte not yet loaded.

Handshakes:
- rx: rx_valid stays high until the cycle where rx_valid && rx_ready; it clears the next cycle.
- tx: holding register captures io_tx_payload when tx_valid && tx_ready; tx_ready drops the next cycle.
- A tx load and a new capture in the same cycle: the loaded byte goes to tx_shift and the new byte fills the holding register.

Simultaneous events:
- Synchronised sclk and ss edges in the same cycle: the ss edge has priority.
- Reset at any point returns to WAIT_IDLE.

Optional Feature:
- Macro: SPI_TARGET_RXFIFO_EN.
- Defined: the rx path gets a 4-entry FIFO (2-bit pointers plus a full/empty count).
  - rx_valid means the FIFO is not empty; rx_payload is the FIFO head.
  - A completed byte is written when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - A byte is dropped with an overrun pulse only when the FIFO is full and there is no pop.
- Undefined: single rx register, as described in Behaviour.

Test Plan:
- tx holds 8'hA5 and ss falls; initiator sends mosi 8'h3C at sclk = io_clock/16 -> miso bits 1,0,1,0,0,1,0,1; rx_payload=8'h3C with rx_valid high; underrun never pulses.
- Empty holding register, 2-byte frame -> miso = 8'hFF then 8'hFF; underrun pulses twice (frame start, then the byte-2 reload).
- rx_ready held 0, bytes 8'h11, 8'h22, 8'h33 -> rx_payload stays 8'h11 and overrun pulses twice. With SPI_TARGET_RXFIFO_EN: 5 bytes give one overrun, and pops return 8'h11..8'h44 in order.
- ss deasserted after 5 bits -> no rx_valid, no overrun; miso_oe=0 and miso=1 within SYNC_STAGES+2 cycles; the next full frame delivers its byte correctly.
- io_reset asserted mid-byte with ss still low -> outputs at reset values; remaining clocks ignored (no rx_valid); after ss goes high then low, a byte 8'h5A is received correctly.
- Back-to-back frame: tx_valid pulses 8'hC3 during byte 1 -> byte 2 on miso = 8'hC3; tx_ready returns to 1 at the byte-2 load.
